// File: rtl/led_scan_sequencer.sv
// -----------------------------------------------------------------------------
// led_scan_sequencer
//
// Generates the raster/PWM scan for a 64x64 LED panel. One (x, y, frame,
// subframe) coordinate is issued per SHIFT cycle to a pipelined pixel painter.
// pix_valid marks the cycles where the painter's registered rgb24 is valid.
// When a row is fully shifted, the sequencer asks the panel driver to latch it
// with a latch_req/latch_ack handshake. It then advances the row, subframe
// (PWM) and frame (animation) counters.
//
// Row timeline (L = PAINTER_LATENCY):
//   SHIFT x64 -> DRAIN xL -> LATCH (until ack) -> NEXT x1 -> SHIFT | IDLE
//
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   enable       in   run request, sampled only in IDLE and NEXT
//   shift_ready  in   row shifter can take a new row, sampled in IDLE and NEXT
//   latch_ack    in   panel driver latched the row (level, sampled in LATCH)
//   x            out  column coordinate to painter (0..63)
//   y            out  row coordinate to painter (0..63)
//   frame        out  animation frame, wraps modulo 2^FRAME_BITS
//   subframe     out  PWM subframe, counts 0..2^SUBFRAME_BITS-2
//   pix_valid    out  painter output valid this cycle
//   latch_req    out  request latch of row row_addr
//   row_addr     out  row being latched, stable while latch_req=1
//   frame_start  out  pulse with the first pixel of row 0, subframe 0
//   busy         out  sequencer is not IDLE
// -----------------------------------------------------------------------------
module led_scan_sequencer #(
  parameter int unsigned FRAME_BITS      = 6,
  parameter int unsigned SUBFRAME_BITS   = 8,
  parameter int unsigned DELAY           = 1,  // sweeps per frame, 1..255
  parameter int unsigned PAINTER_LATENCY = 1   // painter depth, 1..4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     shift_ready,
  input  logic                     latch_ack,
  output logic [5:0]               x,
  output logic [5:0]               y,
  output logic [FRAME_BITS-1:0]    frame,
  output logic [SUBFRAME_BITS-1:0] subframe,
  output logic                     pix_valid,
  output logic                     latch_req,
  output logic [5:0]               row_addr,
  output logic                     frame_start,
  output logic                     busy
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  // Last legal subframe value: the all-ones code is never used, so an 8-bit
  // subframe gives 255 PWM steps.
  localparam logic [SUBFRAME_BITS-1:0] SUB_LAST =
    SUBFRAME_BITS'((1 << SUBFRAME_BITS) - 2);
  localparam logic [7:0] PASS_LAST  = 8'(DELAY - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(PAINTER_LATENCY - 1);

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [2:0]                 state,       state_d;
  logic [5:0]                 x_d,         y_d,        row_addr_d;
  logic [FRAME_BITS-1:0]      frame_d;
  logic [SUBFRAME_BITS-1:0]   subframe_d;
  logic [7:0]                 pass_cnt,    pass_cnt_d;
  logic [1:0]                 drain_cnt,   drain_cnt_d;
  logic                       latch_req_d;
  logic                       frame_start_d;
  logic [PAINTER_LATENCY-1:0] vld_pipe;
  logic                       issue;

  // A coordinate goes to the painter on every SHIFT cycle.
  assign issue = (state == ST_SHIFT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a value unassigned; otherwise synthesis would infer latches.
    state_d     = state;
    x_d         = x;
    y_d         = y;
    frame_d     = frame;
    subframe_d  = subframe;
    pass_cnt_d  = pass_cnt;
    drain_cnt_d = drain_cnt;
    latch_req_d = latch_req;
    row_addr_d  = row_addr;

    case (state)
      ST_IDLE: begin
        if (enable && shift_ready) begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (x == 6'd63) begin
          x_d         = 6'd0;
          drain_cnt_d = 2'd0;
          state_d     = ST_DRAIN;
        end else begin
          x_d = x + 6'd1;
        end
      end

      // Wait for the painter pipeline to empty. The last pix_valid of the row
      // is in the final DRAIN cycle.
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d     = ST_LATCH;
          latch_req_d = 1'b1;
          row_addr_d  = y;
        end else begin
          drain_cnt_d = drain_cnt + 2'd1;
        end
      end

      // latch_req is registered, so it stays high for at least one cycle
      // even when the ack is already waiting on entry.
      ST_LATCH: begin
        if (latch_ack) begin
          latch_req_d = 1'b0;
          state_d     = ST_NEXT;
        end
      end

      // All counter updates happen together, one cycle after the latch.
      ST_NEXT: begin
        y_d = y + 6'd1;
        if (y == 6'd63) begin
          if (subframe == SUB_LAST) begin
            subframe_d = '0;
            if (pass_cnt == PASS_LAST) begin
              pass_cnt_d = 8'd0;
              frame_d    = frame + FRAME_BITS'(1);
            end else begin
              pass_cnt_d = pass_cnt + 8'd1;
            end
          end else begin
            subframe_d = subframe + SUBFRAME_BITS'(1);
          end
        end
        state_d = (enable && shift_ready) ? ST_SHIFT : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered pulse that lines up with the first pixel of row 0 in
    // subframe 0. x_d is 0 only on the transition into SHIFT.
    frame_start_d = (state_d == ST_SHIFT) && (x_d == 6'd0) &&
                    (y_d == 6'd0) && (subframe_d == '0);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: every register here is a control or datapath flop with a defined
    // power-up value. Nothing here is a storage array, so all of them go on
    // the asynchronous reset, including the pix_valid delay line.
    if (!resetn) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      frame       <= '0;
      subframe    <= '0;
      pass_cnt    <= '0;
      drain_cnt   <= '0;
      latch_req   <= 1'b0;
      row_addr    <= '0;
      frame_start <= 1'b0;
      vld_pipe    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values from
      // before this edge no matter what order the statements are in.
      state       <= state_d;
      x           <= x_d;
      y           <= y_d;
      frame       <= frame_d;
      subframe    <= subframe_d;
      pass_cnt    <= pass_cnt_d;
      drain_cnt   <= drain_cnt_d;
      latch_req   <= latch_req_d;
      row_addr    <= row_addr_d;
      frame_start <= frame_start_d;
      // Delay line modelling the painter depth. Bit 0 holds the issue flag
      // of the previous cycle.
      vld_pipe    <= (vld_pipe << 1) | PAINTER_LATENCY'(issue);
    end
  end

  assign pix_valid = vld_pipe[PAINTER_LATENCY-1];
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_led_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_scan_sequencer
//
// Self-checking bench for led_scan_sequencer. Small counter widths keep a full
// frame wrap within a short run. Every row is checked cycle by cycle against
// the timeline that follows from the row structure: 64 issue cycles, L drain
// cycles, a latch that waits for the ack, and one NEXT cycle. The expected
// y/subframe/frame come from the number of completed rows alone, using plain
// division and modulo.
// -----------------------------------------------------------------------------
module tb_led_scan_sequencer;

  localparam int FB   = 1;
  localparam int SB   = 2;
  localparam int DLY  = 2;
  localparam int LAT  = 3;
  localparam int SUBS = (1 << SB) - 1;  // PWM steps per sweep

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          enable = 1'b0;
  logic          shift_ready = 1'b0;
  logic          latch_ack = 1'b0;
  logic [5:0]    x, y, row_addr;
  logic [FB-1:0] frame;
  logic [SB-1:0] subframe;
  logic          pix_valid, latch_req, frame_start, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rows   = 0;  // rows completed since the last reset

  always #5 clk = ~clk;

  led_scan_sequencer #(
    .FRAME_BITS     (FB),
    .SUBFRAME_BITS  (SB),
    .DELAY          (DLY),
    .PAINTER_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .shift_ready(shift_ready),
    .latch_ack  (latch_ack),
    .x          (x),
    .y          (y),
    .frame      (frame),
    .subframe   (subframe),
    .pix_valid  (pix_valid),
    .latch_req  (latch_req),
    .row_addr   (row_addr),
    .frame_start(frame_start),
    .busy       (busy)
  );

  // Reference model: coordinates of row n after reset.
  function automatic int exp_y(input int n);
    return n % 64;
  endfunction

  function automatic int exp_sub(input int n);
    return (n / 64) % SUBS;
  endfunction

  function automatic int exp_frame(input int n);
    return ((n / 64) / SUBS / DLY) % (1 << FB);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h (time %0t)", tag, obs,
             exp, $time);
    end
  endtask

  task automatic check_cleared(input string phase);
    check({phase, " x"},           x,           0);
    check({phase, " y"},           y,           0);
    check({phase, " frame"},       frame,       0);
    check({phase, " subframe"},    subframe,    0);
    check({phase, " pix_valid"},   pix_valid,   0);
    check({phase, " latch_req"},   latch_req,   0);
    check({phase, " row_addr"},    row_addr,    0);
    check({phase, " frame_start"}, frame_start, 0);
    check({phase, " busy"},        busy,        0);
  endtask

  // Async reset: outputs must clear before any clock edge arrives.
  task automatic do_reset(input string phase);
    resetn      = 1'b0;
    latch_ack   = 1'b0;
    enable      = 1'b0;
    shift_ready = 1'b0;
    #1;
    check_cleared({phase, " immediate"});
    @(negedge clk);
    check_cleared({phase, " held"});
    resetn = 1'b1;
    n_rows = 0;
  endtask

  // Idle cycles: enable and shift_ready are never both high, so the block
  // must stay in IDLE with its counters retained.
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle busy",        busy,        0);
      check("idle x",           x,           0);
      check("idle y",           y,           exp_y(n_rows));
      check("idle subframe",    subframe,    exp_sub(n_rows));
      check("idle frame",       frame,       exp_frame(n_rows));
      check("idle pix_valid",   pix_valid,   0);
      check("idle latch_req",   latch_req,   0);
      check("idle frame_start", frame_start, 0);
      enable      = 1'($urandom_range(1, 0));
      shift_ready = enable ? 1'b0 : 1'($urandom_range(1, 0));
      latch_ack   = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic go();
    enable      = 1'b1;
    shift_ready = 1'b1;
  endtask

  // One full row, starting at the first SHIFT cycle (k = 0).
  //   ack_delay : LATCH cycles with ack low before it is raised
  //   cont      : request the next row at the NEXT decision
  //   abort_k   : cycle at which resetn is pulled low (-1 = never)
  task automatic run_row(input int ack_delay, input bit cont,
                         input int abort_k);
    int k_l, k_n, ey, es, ef;
    bit in_latch;
    k_l = 64 + LAT;
    k_n = k_l + ack_delay + 1;
    ey  = exp_y(n_rows);
    es  = exp_sub(n_rows);
    ef  = exp_frame(n_rows);
    for (int k = 0; k <= k_n; k++) begin
      @(negedge clk);
      in_latch = (k >= k_l) && (k <= k_l + ack_delay);
      check("busy",        busy,        1);
      check("x",           x,           (k < 64) ? k : 0);
      check("y",           y,           ey);
      check("subframe",    subframe,    es);
      check("frame",       frame,       ef);
      check("pix_valid",   pix_valid,   (k >= LAT) && (k < 64 + LAT));
      check("latch_req",   latch_req,   in_latch);
      if (in_latch) check("row_addr", row_addr, ey);
      check("frame_start", frame_start, (k == 0) && (ey == 0) && (es == 0));
      if (k == abort_k) begin
        do_reset((k < k_l) ? "reset in DRAIN" : "reset in LATCH");
        return;
      end
      // Inputs for the coming edge. Outside their decision points the
      // handshake inputs are randomized, since they must have no effect there.
      if (in_latch) latch_ack = (k >= k_l + ack_delay);
      else          latch_ack = 1'($urandom_range(1, 0));
      if (k == k_n) begin
        if (cont) begin
          go();
        end else if ($urandom_range(1, 0) == 1) begin
          enable      = 1'b0;
          shift_ready = 1'($urandom_range(1, 0));
        end else begin
          enable      = 1'b1;
          shift_ready = 1'b0;
        end
      end else begin
        enable      = 1'($urandom_range(1, 0));
        shift_ready = 1'($urandom_range(1, 0));
      end
    end
    n_rows++;
  endtask

  initial begin
    bit stop;

    // Power-up reset.
    #3;
    do_reset("power-up reset");
    idle(4);

    // First rows with immediate ack: checks pix_valid timing and the 69-cycle
    // row period at latency 3.
    go();
    for (int r = 0; r < 5; r++) run_row(0, 1'b1, -1);
    // Row 5: ack withheld for 10 latch cycles.
    run_row(10, 1'b1, -1);
    run_row(0, 1'b1, -1);
    // Row 7 ends with no run request: it completes, then the block idles at
    // y = 8.
    run_row(1, 1'b0, -1);
    idle(5);

    // Resume at row 8, then reset in the middle of DRAIN.
    go();
    run_row(0, 1'b1, 64 + 1);
    idle(3);

    // After reset the first latch is for row 0. Reset again while LATCH is
    // waiting for the ack.
    go();
    run_row(6, 1'b1, 64 + LAT + 2);
    idle(3);

    // Long randomized run through subframe, pass and frame wraps, with
    // occasional stops.
    go();
    for (int r = 0; r < 780; r++) begin
      stop = (r % 97) == 96;
      run_row(int'($urandom_range(3, 0)), !stop, -1);
      if (stop) begin
        idle(2);
        go();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
